operand_stage: RTL and testbench
================================

# operand_stage

Issue/operand-fetch stage directly upstream of the combinational ALU. Holds the architectural register file and the carry/zero/parity flag register, reads two operands per issued instruction, and presents `alu_cmd`, `inA`, `inB` and `sc_i` from a pipeline register one cycle later. Also accepts write-back of ALU results and ALU flags. Supports stall, flush and write-back bypass, both at capture and while stalled.

## Interface
Parameters:
- `DW`, 8: datapath width, matching the ALU.
- `NREG`, 8: number of registers; `AW = $clog2(NREG)`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: an instruction is presented this cycle.
- `issue_cmd`  in  3: ALU command to forward.
- `ra_addr`, `rb_addr`  in  AW each: source register addresses.
- `use_imm`  in  1: when set, `inB` takes `imm` instead of register `rb_addr`.
- `imm`  in  DW: immediate operand.
- `stall`  in  1: hold the pipeline register.
- `flush`  in  1: invalidate the pipeline register.
- `wb_en`  in  1: write-back enable.
- `wb_addr`  in  AW: write-back register address.
- `wb_data`  in  DW: write-back data (ALU `rslt`).
- `flag_en`  in  1: capture the ALU flags this cycle.
- `sc_in`, `zero_in`, `pari_in`  in  1 each: ALU `sc_o`, `zero`, `pari`.
- `ex_valid`  out  1: pipeline register holds a live instruction.
- `alu_cmd`  out  3: registered command.
- `inA`, `inB`  out  DW each: registered operands.
- `sc_i`  out  1: carry flag register, fed to the ALU.
- `flag_zero`, `flag_pari`  out  1 each: stored flags.

## Operation
- Register file: NREG×DW. Reads are combinational. Write occurs at the clock edge when `wb_en`. There is no hard-wired zero register.
- Capture (rising edge):
  - If `!stall && !flush`, capture `ex_valid` ← `issue_valid`, together with cmd, operands, the source addresses and `use_imm`.
  - Operand A = `wb_data` if `wb_en && wb_addr==ra_addr`; otherwise `reg[ra_addr]`.
  - Operand B = `imm` if `use_imm`. Otherwise it is `wb_data` on an address match, else `reg[rb_addr]`.
  - Data fields are captured even when `issue_valid` is 0. Downstream ignores them.
- Stall (`stall && !flush`):
  - All pipeline fields hold.
  - Exception: if `wb_en` and `wb_addr` equals the held A source, `inA` ← `wb_data`.
  - Same for B, but only when the held `use_imm` is 0.
- Flush:
  - `ex_valid` ← 0 at the next edge; data fields are don't-care.
  - `flush` has priority over `stall`. `flush` and `issue_valid` together drop the issue.
- Flags:
  - When `flag_en`, {`sc_i`,`flag_zero`,`flag_pari`} ← {`sc_in`,`zero_in`,`pari_in`} at the edge. Otherwise they hold.
  - Flags are independent of `stall` and `flush`.
- The `issue_cmd` encoding is passed through unchanged; this stage does not decode it.

## Timing
- Issue-to-`inA`/`inB` latency is 1 cycle. Register write-to-read visibility is 0 cycles through the bypass, or 1 cycle through the array.
- Reset (asynchronous assert, synchronous-safe deassert by the system) clears:
  - all registers to 0;
  - `ex_valid`, `alu_cmd`, `inA`, `inB` to 0;
  - `sc_i`, `flag_zero`, `flag_pari` to 0.
- Reset asserted mid-operation wins over every concurrent write, capture or flag update in that cycle.
- When `wb_addr` equals both `ra_addr` and `rb_addr`, both operands get `wb_data`.
- `flag_en` and `wb_en` may be asserted in the same cycle; they are independent.
- `wb_addr ≥ NREG` (non-power-of-two NREG) is ignored: no write and no bypass.

## Structure
- Package `alu_pkg` holds:
  - `DW` and `NREG` defaults;
  - `alu_cmd_t` enum: ADD=000, SUB=001, SHR=010, SHL=011, XOR=100, RXOR=101, AND=110, NOP=111;
  - a packed `ex_reg_t` struct {valid, cmd, a, b, a_src, b_src, use_imm}.
- Sub-module `reg_file_core`: the array, one write port and two combinational read ports, with no bypass. Bypass, pipeline register and flags live in `operand_stage`.

## Test plan
- Reset then issue ADD with ra=1, rb=2 and no prior writes → next cycle `ex_valid`=1, `alu_cmd`=000, `inA`=0, `inB`=0, `sc_i`=0.
- Write r3=0x5A. Next cycle issue ra=3, `use_imm`=1, imm=0x0F → `inA`=0x5A, `inB`=0x0F after 1 cycle.
- Same-cycle bypass: issue ra=4, rb=4 with `wb_en`, `wb_addr`=4, `wb_data`=0xC3 → `inA`=`inB`=0xC3. r4 reads 0xC3 afterward.
- Stall hold and refresh: capture ra=5 (0x11), rb=imm 0x22. Stall 3 cycles, writing r5=0x99 in cycle 2 → `inA`=0x99 from cycle 3, `inB` stays 0x22, `ex_valid` stays 1.
- Flush with stall and issue asserted together → `ex_valid`=0 next cycle. `flag_en` in the same cycle with `sc_in`=1, `zero_in`=0, `pari_in`=1 → `sc_i`=1, `flag_zero`=0, `flag_pari`=1.
- Assert `reset` mid-stall, with `wb_en` to r2=0xFF in the same cycle → all outputs 0 immediately. After release, reading r2 gives 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU command encoding, default sizes and the execute pipeline register layout
package alu_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int NREG_DEFAULT = 8;
  localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    SHR  = 3'b010,
    SHL  = 3'b011,
    XOR  = 3'b100,
    RXOR = 3'b101,
    AND  = 3'b110,
    NOP  = 3'b111
  } alu_cmd_t;

  // The source addresses and use_imm are kept alongside the operands so a
  // stalled instruction can still pick up a write-back aimed at its sources.
  typedef struct packed {
    logic                  valid;
    alu_cmd_t              cmd;
    logic [DW_DEFAULT-1:0] a;
    logic [DW_DEFAULT-1:0] b;
    logic [AW_DEFAULT-1:0] a_src;
    logic [AW_DEFAULT-1:0] b_src;
    logic                  use_imm;
  } ex_reg_t;

endpackage

// File: rtl/reg_file_core.sv
// rtl/reg_file_core.sv - register array with one write port and two combinational read ports
//
// Purpose: NREG x DW architectural registers, cleared by reset, no bypass.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   we, waddr, wdata    write port (caller guarantees waddr < NREG when we)
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
module reg_file_core #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - operand fetch stage feeding the combinational ALU
//
// Purpose: reads two operands per issued instruction (with write-back bypass),
// holds them in a pipeline register with stall/flush, and keeps the ALU flags.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   issue_valid, issue_cmd              instruction presented this cycle
//   ra_addr, rb_addr, use_imm, imm      operand sources
//   stall, flush                        pipeline register control
//   wb_en, wb_addr, wb_data             register write-back
//   flag_en, sc_in, zero_in, pari_in    ALU flag capture
//   ex_valid, alu_cmd, inA, inB         registered instruction to the ALU
//   sc_i, flag_zero, flag_pari          stored flags
module operand_stage
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [2:0]    issue_cmd,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic          use_imm,
  input  logic [DW-1:0] imm,
  input  logic          stall,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flag_en,
  input  logic          sc_in,
  input  logic          zero_in,
  input  logic          pari_in,
  output logic          ex_valid,
  output logic [2:0]    alu_cmd,
  output logic [DW-1:0] inA,
  output logic [DW-1:0] inB,
  output logic          sc_i,
  output logic          flag_zero,
  output logic          flag_pari
);

  ex_reg_t       ex;
  logic          wb_ok;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // Out-of-range write-back addresses only exist for non-power-of-two NREG;
  // they neither write nor bypass.
  if (NREG == (1 << AW)) begin : g_pow2
    assign wb_ok = wb_en;
  end else begin : g_npow2
    assign wb_ok = wb_en && (int'(wb_addr) < NREG);
  end

  reg_file_core #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_ok),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ra_addr),
    .rdata_a (rd_a),
    .raddr_b (rb_addr),
    .rdata_b (rd_b)
  );

  // Same-cycle bypass so a result written this edge is visible to the issue.
  assign op_a = (wb_ok && wb_addr == ra_addr) ? wb_data : rd_a;
  assign op_b = use_imm                        ? imm     :
                (wb_ok && wb_addr == rb_addr) ? wb_data : rd_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex <= '0;
    end else if (flush) begin
      ex.valid <= 1'b0;
    end else if (stall) begin
      // Held instruction still sees write-backs to its register sources.
      if (wb_ok && wb_addr == ex.a_src) begin
        ex.a <= wb_data;
      end
      if (!ex.use_imm && wb_ok && wb_addr == ex.b_src) begin
        ex.b <= wb_data;
      end
    end else begin
      ex.valid   <= issue_valid;
      ex.cmd     <= alu_cmd_t'(issue_cmd);
      ex.a       <= op_a;
      ex.b       <= op_b;
      ex.a_src   <= ra_addr;
      ex.b_src   <= rb_addr;
      ex.use_imm <= use_imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_i      <= 1'b0;
      flag_zero <= 1'b0;
      flag_pari <= 1'b0;
    end else if (flag_en) begin
      sc_i      <= sc_in;
      flag_zero <= zero_in;
      flag_pari <= pari_in;
    end
  end

  assign ex_valid = ex.valid;
  assign alu_cmd  = ex.cmd;
  assign inA      = ex.a;
  assign inB      = ex.b;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - self-checking bench for operand_stage
module tb_operand_stage;

  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [2:0]    issue_cmd;
  logic [AW-1:0] ra_addr, rb_addr;
  logic          use_imm;
  logic [DW-1:0] imm;
  logic          stall, flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flag_en, sc_in, zero_in, pari_in;
  logic          ex_valid;
  logic [2:0]    alu_cmd;
  logic [DW-1:0] inA, inB;
  logic          sc_i, flag_zero, flag_pari;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Reference model state
  logic [DW-1:0] m_regs [NREG];
  logic          e_valid;
  logic [2:0]    e_cmd;
  logic [DW-1:0] e_a, e_b;
  logic [AW-1:0] m_asrc, m_bsrc;
  logic          m_imm;
  logic          e_sc, e_z, e_p;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_cmd   (issue_cmd),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .use_imm     (use_imm),
    .imm         (imm),
    .stall       (stall),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_en     (flag_en),
    .sc_in       (sc_in),
    .zero_in     (zero_in),
    .pari_in     (pari_in),
    .ex_valid    (ex_valid),
    .alu_cmd     (alu_cmd),
    .inA         (inA),
    .inB         (inB),
    .sc_i        (sc_i),
    .flag_zero   (flag_zero),
    .flag_pari   (flag_pari)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_step();
    bit ok;
    ok = wb_en && (int'(wb_addr) < NREG);
    if (!reset) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      e_valid = 0; e_cmd = 0; e_a = 0; e_b = 0;
      m_asrc = 0; m_bsrc = 0; m_imm = 0;
      e_sc = 0; e_z = 0; e_p = 0;
      return;
    end
    if (flush) begin
      e_valid = 0;
    end else if (stall) begin
      if (ok && wb_addr == m_asrc) e_a = wb_data;
      if (!m_imm && ok && wb_addr == m_bsrc) e_b = wb_data;
    end else begin
      e_valid = issue_valid;
      e_cmd   = issue_cmd;
      e_a     = (ok && wb_addr == ra_addr) ? wb_data : m_regs[ra_addr];
      if (use_imm) e_b = imm;
      else         e_b = (ok && wb_addr == rb_addr) ? wb_data : m_regs[rb_addr];
      m_asrc = ra_addr;
      m_bsrc = rb_addr;
      m_imm  = use_imm;
    end
    if (flag_en) begin
      e_sc = sc_in; e_z = zero_in; e_p = pari_in;
    end
    if (ok) m_regs[wb_addr] = wb_data;
  endtask

  // Inputs are applied 1 time unit after a falling edge; this advances one cycle.
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_cmd = 0; ra_addr = 0; rb_addr = 0;
    use_imm = 0; imm = 0; stall = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    flag_en = 0; sc_in = 0; zero_in = 0; pari_in = 0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("ex_valid", 32'(ex_valid), 32'(e_valid));
      check("sc_i", 32'(sc_i), 32'(e_sc));
      check("flag_zero", 32'(flag_zero), 32'(e_z));
      check("flag_pari", 32'(flag_pari), 32'(e_p));
      if (e_valid) begin
        check("alu_cmd", 32'(alu_cmd), 32'(e_cmd));
        check("inA", 32'(inA), 32'(e_a));
        check("inB", 32'(inB), 32'(e_b));
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 0;
    model_step();
    @(negedge clk); #1;
    @(negedge clk); #1;
    started = 1;
    check("rst ex_valid", 32'(ex_valid), 0);
    check("rst alu_cmd", 32'(alu_cmd), 0);
    check("rst inA", 32'(inA), 0);
    check("rst inB", 32'(inB), 0);
    check("rst flags", {29'd0, sc_i, flag_zero, flag_pari}, 0);
    reset = 1;
    step();

    // ADD r1, r2 with empty register file
    issue_valid = 1; issue_cmd = 3'b000; ra_addr = 1; rb_addr = 2;
    step();
    check("add ex_valid", 32'(ex_valid), 1);
    check("add alu_cmd", 32'(alu_cmd), 0);
    check("add inA", 32'(inA), 0);
    check("add inB", 32'(inB), 0);
    check("add sc_i", 32'(sc_i), 0);

    // Array write then immediate-operand issue
    idle_inputs(); wb_en = 1; wb_addr = 3; wb_data = 8'h5A;
    step();
    idle_inputs(); issue_valid = 1; issue_cmd = 3'b100; ra_addr = 3; use_imm = 1; imm = 8'h0F;
    step();
    check("imm inA", 32'(inA), 32'h5A);
    check("imm inB", 32'(inB), 32'h0F);

    // Same-cycle bypass on both operands
    idle_inputs(); issue_valid = 1; issue_cmd = 3'b001; ra_addr = 4; rb_addr = 4;
    wb_en = 1; wb_addr = 4; wb_data = 8'hC3;
    step();
    check("byp inA", 32'(inA), 32'hC3);
    check("byp inB", 32'(inB), 32'hC3);
    wb_en = 0;
    step();
    check("r4 inA", 32'(inA), 32'hC3);
    check("r4 inB", 32'(inB), 32'hC3);

    // Stall hold and refresh
    idle_inputs(); wb_en = 1; wb_addr = 5; wb_data = 8'h11;
    step();
    idle_inputs(); issue_valid = 1; issue_cmd = 3'b110; ra_addr = 5; use_imm = 1; imm = 8'h22;
    step();
    check("cap inA", 32'(inA), 32'h11);
    check("cap inB", 32'(inB), 32'h22);
    idle_inputs(); stall = 1; issue_valid = 1; ra_addr = 0;
    step();
    check("stall1 inA", 32'(inA), 32'h11);
    wb_en = 1; wb_addr = 5; wb_data = 8'h99;
    step();
    check("stall2 inA", 32'(inA), 32'h99);
    check("stall2 inB", 32'(inB), 32'h22);
    wb_en = 0;
    step();
    check("stall3 inA", 32'(inA), 32'h99);
    check("stall3 inB", 32'(inB), 32'h22);
    check("stall3 valid", 32'(ex_valid), 1);

    // Flush beats stall and issue; flags independent
    idle_inputs(); flush = 1; stall = 1; issue_valid = 1;
    flag_en = 1; sc_in = 1; zero_in = 0; pari_in = 1;
    step();
    check("flush valid", 32'(ex_valid), 0);
    check("flush flags", {29'd0, sc_i, flag_zero, flag_pari}, 32'b101);

    // Reset mid-stall with a concurrent write
    idle_inputs(); issue_valid = 1; ra_addr = 3;
    step();
    check("pre-rst inA", 32'(inA), 32'h5A);
    idle_inputs(); stall = 1; wb_en = 1; wb_addr = 2; wb_data = 8'hFF; reset = 0;
    #1;
    check("arst outputs", {20'd0, ex_valid, alu_cmd, inA, sc_i, flag_zero, flag_pari},
          {20'd0, 1'b0, 3'd0, 8'd0, 3'd0});
    check("arst inB", 32'(inB), 0);
    step();
    reset = 1; idle_inputs();
    step();
    issue_valid = 1; ra_addr = 2; rb_addr = 2;
    step();
    check("r2 after rst A", 32'(inA), 0);
    check("r2 after rst B", 32'(inB), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_cmd   = 3'($urandom);
      ra_addr     = AW'($urandom);
      rb_addr     = AW'($urandom);
      use_imm     = ($urandom_range(0, 9) < 3);
      imm         = DW'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_addr     = AW'($urandom);
      wb_data     = DW'($urandom);
      flag_en     = ($urandom_range(0, 9) < 3);
      sc_in       = 1'($urandom);
      zero_in     = 1'($urandom);
      pari_in     = 1'($urandom);
      reset       = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
